// File: rtl/primus_alu_pkg.sv
// Purpose: shared op encodings for the primus execute-stage ALU pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package primus_alu_pkg;

  localparam int ALU_OP_W = 4;

  // Codes 10..15 are deliberately left unassigned and decode as illegal.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

endpackage

// File: rtl/primus_pipe_stage.sv
// Purpose: one valid/ready register slice carrying an opaque payload.
// Latency: 1 cycle from up_valid to dn_valid when not stalled.
// Backpressure: holds its entry while full and dn_ready is low; loads whenever empty.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   up_valid, up_data   entry offered by the previous slice (or the issue side)
//   dn_valid, dn_data   registered entry presented downstream
//   dn_ready            downstream slice will move this cycle (or the consumer accepts)
//
// The matching upstream-ready is not produced here: the owning pipeline derives
// every slice's readiness from the valid bits directly, which keeps the ready
// path free of slice-to-slice combinational chaining.
module primus_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  // A slice moves when it is empty (bubble collapsing) or its occupant leaves.
  logic advance;
  assign advance = !dn_valid || dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (advance) begin
      dn_valid <= up_valid;
      // Data only changes when a real entry arrives; bubbles leave it alone.
      if (up_valid) begin
        dn_data <= up_data;
      end
    end
  end

endmodule

// File: rtl/primus_alu_pipe.sv
// Purpose: pipelined integer ALU for the execute stage, carrying a tag with each op.
// Latency: STAGES cycles from accept to valid_o when the output is not stalled.
// Backpressure: bubble-collapsing valid/ready; ready_o depends combinationally on ready_i.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   valid_i, ready_o              issue handshake
//   op_i, rs1_i, rs2_i, tag_i     operation, operands, opaque tag
//   valid_o, ready_i              result handshake
//   result_o, zero_o, err_o, tag_o result, result==0 flag, illegal-op flag, returned tag
import primus_alu_pkg::*;

module primus_alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    rs1_i,
  input  logic [WIDTH-1:0]    rs2_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                zero_o,
  output logic                err_o,
  output logic [TAG_W-1:0]    tag_o
);

  localparam int SH_W = $clog2(WIDTH);
  // Payload layout, MSB first: {err, zero, tag, result}.
  localparam int P_W  = WIDTH + TAG_W + 2;

  // ---------------------------------------------------------------------------
  // Compute (combinational, registered by the first slice)
  // ---------------------------------------------------------------------------
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] res;
  logic             res_err;
  logic             res_zero;

  // Only the low log2(WIDTH) bits of rs2 select the shift distance.
  assign shamt = rs2_i[SH_W-1:0];

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op_i)
      ALU_ADD:  res = rs1_i + rs2_i;
      ALU_SUB:  res = rs1_i - rs2_i;
      ALU_SLL:  res = rs1_i << shamt;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(rs1_i) < $signed(rs2_i)};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, rs1_i < rs2_i};
      ALU_XOR:  res = rs1_i ^ rs2_i;
      ALU_SRL:  res = rs1_i >> shamt;
      ALU_SRA:  res = $signed(rs1_i) >>> shamt;
      ALU_OR:   res = rs1_i | rs2_i;
      ALU_AND:  res = rs1_i & rs2_i;
      default:  res_err = 1'b1;   // illegal codes yield a zero result
    endcase
  end

  // Zero flag is captured alongside the result rather than recomputed at the
  // output, so the output stage carries no comparator.
  assign res_zero = (res == '0);

  // ---------------------------------------------------------------------------
  // Register slices
  // ---------------------------------------------------------------------------
  // Index 0 is the issue side; index k (1..STAGES) is the output of slice k.
  logic [STAGES:0] stg_vld;
  logic [P_W-1:0]  stg_dat [STAGES+1];

  assign stg_vld[0] = valid_i;
  assign stg_dat[0] = {res_err, res_zero, tag_i, res};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic dn_rdy;

    // A slice's downstream neighbour moves when the consumer accepts or when
    // any slice from that neighbour to the output is empty. This is the
    // unrolled form of "empty or next advances", computed from valid bits only.
    if (k == STAGES - 1) begin : g_last
      assign dn_rdy = ready_i;
    end else begin : g_mid
      assign dn_rdy = ready_i || !(&stg_vld[STAGES:k+2]);
    end

    primus_pipe_stage #(
      .W (P_W)
    ) u_stage (
      .clk      (clk_i),
      .rst      (rst_i),
      .up_valid (stg_vld[k]),
      .up_data  (stg_dat[k]),
      .dn_valid (stg_vld[k+1]),
      .dn_data  (stg_dat[k+1]),
      .dn_ready (dn_rdy)
    );
  end

  // First slice can take an op if it is empty or it will move this cycle,
  // i.e. some slice is empty or the consumer accepts.
  assign ready_o = ready_i || !(&stg_vld[STAGES:1]);

  assign valid_o = stg_vld[STAGES];
  assign {err_o, zero_o, tag_o, result_o} = stg_dat[STAGES];

endmodule

// File: tb/tb_primus_alu_pipe.sv
// Purpose: self-checking bench for primus_alu_pipe using an expected-result queue.
// Latency: checks STAGES-cycle issue-to-result latency on unstalled ops.
// Backpressure: exercises output stalls, full-pipe ready drop and random ready_i.
module tb_primus_alu_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             err_o;
  logic [TAG_W-1:0] tag_o;

  primus_alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .tag_i    (tag_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .err_o    (err_o),
    .tag_o    (tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic             lat_chk;
    int               acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  bit   lat_en  = 1'b0;

  // Snapshot of a stalled output, compared on the following cycle.
  bit               hold_v = 1'b0;
  logic [WIDTH-1:0] hold_res;
  logic             hold_zero;
  logic             hold_err;
  logic [TAG_W-1:0] hold_tag;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference ALU written bit-wise for the shifts and sign-split for SLT.
  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [WIDTH-1:0] r;
    int sh;
    r  = '0;
    e  = '0;
    sh = int'(b[4:0]);
    case (op)
      4'd0: r = a + b;
      4'd1: r = a + (~b) + 32'd1;
      4'd2: for (int i = 0; i < WIDTH; i++) if (i >= sh) r[i] = a[i-sh];
      4'd3: r[0] = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : (a < b);
      4'd4: r[0] = (a < b);
      4'd5: r = a ^ b;
      4'd6: for (int i = 0; i < WIDTH; i++) if (i + sh < WIDTH) r[i] = a[i+sh];
      4'd7: for (int i = 0; i < WIDTH; i++) r[i] = (i + sh < WIDTH) ? a[i+sh] : a[WIDTH-1];
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: e.err = 1'b1;
    endcase
    e.res  = r;
    e.zero = (r == '0);
    e.tag  = tag;
    return e;
  endfunction

  // Monitor: handshakes sampled on the falling edge describe the transfers
  // that happen on the next rising edge.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (rst_i) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid",  valid_o,  1);
        check("hold_result", result_o, hold_res);
        check("hold_zero",   zero_o,   hold_zero);
        check("hold_err",    err_o,    hold_err);
        check("hold_tag",    tag_o,    hold_tag);
      end
      hold_v    = valid_o && !ready_i;
      hold_res  = result_o;
      hold_zero = zero_o;
      hold_err  = err_o;
      hold_tag  = tag_o;

      if (valid_i && ready_o) begin
        e         = model(op_i, rs1_i, rs2_i, tag_i);
        e.lat_chk = lat_en;
        e.acc_cyc = cyc;
        sb.push_back(e);
        acc_cnt++;
      end

      if (valid_o && ready_i) begin
        out_cnt++;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", result_o, e.res);
          check("zero",   zero_o,   e.zero);
          check("err",    err_o,    e.err);
          check("tag",    tag_o,    e.tag);
          if (e.lat_chk) check("latency", cyc - e.acc_cyc, STAGES);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    tag_i   = tag;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (ready_o) break;
    end
    check("send_accept", ready_o, 1);
    @(posedge clk_i);
    #1 valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk_i);
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk_i);
    #1;
  endtask

  int a0;
  int o0;

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    tag_i   = '0;

    // Reset state, before any clock edge has occurred.
    #3;
    check("rst_valid",  valid_o,  0);
    check("rst_result", result_o, 0);
    check("rst_ready",  ready_o,  1);
    check("rst_zero",   zero_o,   0);
    check("rst_err",    err_o,    0);
    check("rst_tag",    tag_o,    0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Wrap-around add, with latency check.
    lat_en = 1'b1;
    send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
    drain();

    // Directed ops issued back to back.
    send(4'd7, 32'h8000_0000, 32'h24, 5'd2);
    send(4'd6, 32'h8000_0000, 32'h24, 5'd3);
    send(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd4);
    send(4'd4, 32'hFFFF_FFFF, 32'd1, 5'd5);
    send(4'd1, 32'd5, 32'd7, 5'd6);
    send(4'd2, 32'h0000_00F1, 32'hFFFF_FFE3, 5'd7);
    send(4'd5, 32'hA5A5_0F0F, 32'h5A5A_0FF0, 5'd8);
    send(4'd8, 32'hA000_000A, 32'h0500_0050, 5'd9);
    send(4'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd10);
    send(4'hF, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
    send(4'hA, 32'd0, 32'd0, 5'd12);
    drain();

    // Back-pressure: 6 ops with the consumer stalled for the first 4 cycles.
    lat_en  = 1'b0;
    ready_i = 1'b0;
    a0      = acc_cnt;
    o0      = out_cnt;
    fork
      begin
        for (int t = 0; t < 6; t++) send(4'd0, 32'(t * 3), 32'd100, 5'(t));
      end
      begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("bp_ready_low", ready_o, 0);
        check("bp_accepts",   acc_cnt - a0, 3);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
      end
    join
    drain();
    check("bp_outputs", out_cnt - o0, 6);

    // Reset with two ops in flight: neither may ever appear.
    send(4'd0, 32'd1, 32'd2, 5'd20);
    send(4'd0, 32'd3, 32'd4, 5'd21);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_valid",  valid_o,  0);
    check("mid_rst_ready",  ready_o,  1);
    check("mid_rst_result", result_o, 0);
    check("mid_rst_tag",    tag_o,    0);
    sb.delete();
    o0 = out_cnt;
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    check("mid_rst_no_output", out_cnt - o0, 0);

    // Random ops under random consumer stalls.
    a0 = acc_cnt;
    fork
      begin
        for (int t = 0; t < 40; t++)
          send(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
      begin
        for (int i = 0; i < 150; i++) begin
          @(posedge clk_i);
          #1 ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check("rand_accepts", acc_cnt - a0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
